vload_responder: RTL
====================

Name: vload_responder

Overview:
- Memory-side counterpart of the vector-lane load writeback path.
- Accepts queued vector-load requests from the issue stage and arms the lane with wait_for_load/load_destination.
- Fetches one DATA_WIDTH word per request over an in-order memory port, then hands the word to the lane with valid_read/data_from_load until the lane reports read_done.
- One instance per lane; sits between the lane and the load/store unit.

Parameters:
- DATA_WIDTH, 64, load data word width.
- ADDR_WIDTH, 32, memory address width.
- REQ_DEPTH, 4, request FIFO entries (power of 2, >=2).
- TIMEOUT_CYCLES, 1024, watchdog limit (only with VLOAD_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  issue-side load request valid
- req_ready  out  1  request FIFO not full
- req_addr  in  ADDR_WIDTH  word address
- req_dest  in  5  destination vector register
- mem_req_valid  out  1  memory read request
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_WIDTH  read address
- mem_resp_valid  in  1  read data valid (in order, single-cycle)
- mem_resp_data  in  DATA_WIDTH  read data
- wait_for_load  out  1  arm lane
- load_destination  out  5  destination presented to lane
- valid_read  out  1  load data valid to lane
- data_from_load  out  DATA_WIDTH  load data to lane
- read_done  in  1  lane consumed data (lane computes its armed flag & valid_read)
- busy  out  1  FIFO non-empty or FSM not IDLE
- timeout_err  out  1  sticky watchdog flag (tied 0 without macro)

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. All outputs reset to 0, FIFO empty, FSM in IDLE, data register cleared. Reset mid-transaction drops the in-flight request; a memory response arriving after reset release while in IDLE is ignored.
- Request FIFO:
  - Push when req_valid & req_ready.
  - req_ready = !full.
  - Simultaneous push and pop when full is not allowed: req_ready is 0 when full.
  - Simultaneous push and pop when non-full keeps the count unchanged.
  - Pointers wrap modulo REQ_DEPTH; count width is clog2(REQ_DEPTH)+1.
- FSM states: IDLE, ARM, MREQ, MWAIT, DELIVER.
  - IDLE: if FIFO non-empty, pop the head into cur_addr/cur_dest and go to ARM.
  - ARM (exactly 1 cycle): wait_for_load=1, load_destination=cur_dest; go to MREQ.
  - MREQ: mem_req_valid=1, mem_addr=cur_addr. On mem_req_ready go to MWAIT.
    - If mem_resp_valid arrives in the same cycle as the handshake, capture the data and go directly to DELIVER.
  - MWAIT: on mem_resp_valid, capture mem_resp_data into data_from_load and go to DELIVER.
  - DELIVER: valid_read=1 and held until read_done=1. On read_done go to IDLE; the next request is popped on the following IDLE cycle. Minimum spacing between deliveries is 3 cycles.
- load_destination holds cur_dest from ARM through DELIVER. The lane latches the destination while unarmed, so it must be stable.
- valid_read is never asserted earlier than 2 cycles after wait_for_load. This guarantees the lane is armed before data appears.
- data_from_load is stable whenever valid_read=1.
- A mem_resp_valid arriving outside MWAIT, or outside the MREQ handshake cycle, is a protocol violation and is ignored.
- busy = (count!=0) | (state!=IDLE).

Optional Feature:
- Macro VLOAD_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in MREQ, MWAIT and DELIVER and clears on entry to IDLE.
  - When it reaches TIMEOUT_CYCLES, timeout_err sets (sticky until rst) and the FSM forces IDLE.
  - valid_read and wait_for_load deassert and the current request is dropped.
- When undefined: no counter, timeout_err tied 0, the FSM waits indefinitely.

Decomposition:
- Shared package vload_pkg:
  - typedef vload_state_e for the FSM states.
  - struct vload_req_t {addr, dest}.
  - constant VREG_IDX_W=5.
- Sub-module vload_req_fifo: parameterised synchronous FIFO of vload_req_t with push/pop/full/empty/count.
- FSM, data register and watchdog live in the top module.

Test Plan:
- Single load: req addr=0x100, dest=7; mem_req_ready=1, response 0xDEADBEEF 2 cycles later -> wait_for_load pulses 1 cycle with load_destination=7; mem_addr=0x100; valid_read=1 with data 0xDEADBEEF until read_done; then busy=0.
- Backpressure: push 5 requests with REQ_DEPTH=4 and mem_req_ready=0 -> req_ready drops after 4 entries are buffered (head popped into FSM makes the 5th acceptable); requests are served in order dest 1..5.
- Lane stall: hold read_done=0 for 10 cycles -> valid_read and data_from_load stay stable, with no new wait_for_load pulse.
- Same-cycle response: mem_resp_valid in the mem_req_ready cycle with data 0x55 -> DELIVER is entered the next cycle with data 0x55.
- Reset in MWAIT: assert rst, then deliver a stray mem_resp_valid -> all outputs 0, FIFO empty, response ignored.
- VLOAD_TIMEOUT_EN with TIMEOUT_CYCLES=16: no memory response -> timeout_err=1 at cycle 16 after leaving ARM, FSM in IDLE, the next queued request proceeds normally.

Source files
------------

// File: rtl/vload_pkg.sv
// Shared types for the vector-load responder: FSM state encoding and request record.
// VREG_IDX_W is the width of a vector register index.
package vload_pkg;

    localparam int VREG_IDX_W   = 5;
    localparam int VLOAD_ADDR_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_MREQ    = 3'd2,
        ST_MWAIT   = 3'd3,
        ST_DELIVER = 3'd4
    } vload_state_e;

    // Canonical request layout at the default address width; the top re-declares
    // it with its own ADDR_WIDTH and hands that type to the FIFO.
    typedef struct packed {
        logic [VLOAD_ADDR_W-1:0] addr;
        logic [VREG_IDX_W-1:0]   dest;
    } vload_req_t;

endpackage

// File: rtl/vload_req_fifo.sv
// Synchronous request FIFO with asynchronous active-high reset.
// DEPTH must be a power of two so the pointers wrap naturally.
module vload_req_fifo
    import vload_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = vload_req_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vload_responder.sv
// Per-lane vector-load responder: queues requests, arms the lane, fetches one word, delivers it.
// Optional watchdog enabled by defining VLOAD_TIMEOUT_EN.
module vload_responder
    import vload_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 32,
    parameter int REQ_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [VREG_IDX_W-1:0] req_dest,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic                  wait_for_load,
    output logic [VREG_IDX_W-1:0] load_destination,
    output logic                  valid_read,
    output logic [DATA_WIDTH-1:0] data_from_load,
    input  logic                  read_done,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int CNT_W = $clog2(REQ_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [VREG_IDX_W-1:0] dest;
    } req_t;

    vload_state_e          state_q;
    vload_state_e          state_d;
    req_t                  push_req;
    req_t                  head_req;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  pop;
    logic                  capture;
    logic                  timeout_hit;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [VREG_IDX_W-1:0] cur_dest;
    logic [DATA_WIDTH-1:0] data_q;

    assign push_req.addr = req_addr;
    assign push_req.dest = req_dest;
    // Held low while rst is asserted so every output reads 0 during reset.
    assign req_ready     = !fifo_full && !rst;

    vload_req_fifo #(
        .DEPTH   (REQ_DEPTH),
        .entry_t (req_t)
    ) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_valid),
        .push_data (push_req),
        .pop       (pop),
        .pop_data  (head_req),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        capture       = 1'b0;
        wait_for_load = 1'b0;
        mem_req_valid = 1'b0;
        valid_read    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                wait_for_load = 1'b1;
                state_d       = ST_MREQ;
            end
            ST_MREQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    // A response coinciding with the handshake is taken at once.
                    if (mem_resp_valid) begin
                        capture = 1'b1;
                        state_d = ST_DELIVER;
                    end else begin
                        state_d = ST_MWAIT;
                    end
                end
            end
            ST_MWAIT: begin
                if (mem_resp_valid) begin
                    capture = 1'b1;
                    state_d = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                valid_read = 1'b1;
                if (read_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (timeout_hit) begin
            capture = 1'b0;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cur_addr <= '0;
            cur_dest <= '0;
            data_q   <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                cur_addr <= head_req.addr;
                cur_dest <= head_req.dest;
            end
            if (capture) data_q <= mem_resp_data;
        end
    end

    // cur_dest and data_q only change on pop/capture, keeping lane-facing values stable.
    assign mem_addr         = cur_addr;
    assign load_destination = cur_dest;
    assign data_from_load   = data_q;
    assign busy             = (fifo_count != '0) || (state_q != ST_IDLE);

`ifdef VLOAD_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TMR_W-1:0] tmr_q;
    logic             tmr_active;
    logic             timeout_q;

    assign tmr_active  = (state_q == ST_MREQ) || (state_q == ST_MWAIT) ||
                         (state_q == ST_DELIVER);
    assign timeout_hit = tmr_active && (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (tmr_active && (state_d != ST_IDLE)) tmr_q <= tmr_q + 1'b1;
            else                                    tmr_q <= '0;
            if (timeout_hit) timeout_q <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
    assign timeout_err        = 1'b0;
`endif

endmodule
